// File: rtl/ack_pkt_pkg.sv
// ---------------------------------------------------------------------------
// ack_pkt_pkg
//   Shared definitions for the ACK fragment path. Both the ACK fragment builder
//   (transmit side) and ack_pkt_parser (receive side) import this package so the
//   header layout is defined in exactly one place.
//
//   Header layout, LSB first:
//     src_router | dst_dfx | 3'b000 | type | src_dfx | dst_dfx (copy) | 1'b0 | rn | ack
//   Every bit of the Aurora fragment above HDR_W is zero.
// ---------------------------------------------------------------------------
package ack_pkt_pkg;

  // Default field widths.
  localparam int ACK_W    = 1;
  localparam int SEQ_W    = 1;
  localparam int DFX_W    = 2;
  localparam int ROUTER_W = 2;
  localparam int AURORA_W = 256;

  localparam int RSV3_W = 3;
  localparam int TYPE_W = 2;
  localparam int RSV1_W = 1;

  // Field offsets inside the fragment.
  localparam int OFS_SRC_ROUTER = 0;
  localparam int OFS_DST_DFX0   = OFS_SRC_ROUTER + ROUTER_W;
  localparam int OFS_RSV3       = OFS_DST_DFX0 + DFX_W;
  localparam int OFS_TYPE       = OFS_RSV3 + RSV3_W;
  localparam int OFS_SRC_DFX    = OFS_TYPE + TYPE_W;
  localparam int OFS_DST_DFX1   = OFS_SRC_DFX + DFX_W;
  localparam int OFS_RSV1       = OFS_DST_DFX1 + DFX_W;
  localparam int OFS_RN         = OFS_RSV1 + RSV1_W;
  localparam int OFS_ACK        = OFS_RN + SEQ_W;
  localparam int HDR_W          = OFS_ACK + ACK_W;

  localparam logic [TYPE_W-1:0] TYPE_ACK = 2'b10;

  // One decoded ACK as stored in the receive FIFO.
  typedef struct packed {
    logic [ROUTER_W-1:0] src_router;
    logic [DFX_W-1:0]    src_dfx;
    logic [DFX_W-1:0]    dst_dfx;
    logic [SEQ_W-1:0]    rn;
  } ack_entry_t;

  localparam int ENTRY_W = $bits(ack_entry_t);

endpackage : ack_pkt_pkg

// File: rtl/ack_sync_fifo.sv
// ---------------------------------------------------------------------------
// ack_sync_fifo
//   Single-clock FIFO with show-ahead output: dout always presents the head
//   entry (zero when empty). A push into a full FIFO is accepted only when a pop
//   happens in the same cycle, so full + push + pop leaves the occupancy at DEPTH.
//
//   Ports
//     clk    in   clock
//     rst    in   synchronous reset, active-high (empties the FIFO)
//     push   in   write din this cycle (ignored when full without pop)
//     din    in   WIDTH  write data
//     pop    in   remove the head entry (ignored when empty)
//     dout   out  WIDTH  head entry, zero when empty
//     full   out  occupancy == DEPTH
//     empty  out  occupancy == 0
//
//   DEPTH must be a power of 2 and >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ack_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic do_push;
  logic do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: the storage array has no reset; stale entries are never visible
  // because dout is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule : ack_sync_fifo

// File: rtl/ack_pkt_parser.sv
// ---------------------------------------------------------------------------
// ack_pkt_parser
//   Receive-side ACK decoder. Registers each incoming Aurora fragment, checks
//   the ACK header, and queues the decoded fields for the send controller.
//   Malformed frames and good frames that find the FIFO full are dropped and
//   counted in saturating counters.
//
//   Pipeline (frame sampled at edge N):
//     edge N   : stage 1 captures the fragment
//     edge N+1 : stage 2 captures the header verdict and decoded fields
//     edge N+2 : push into the FIFO / bump a drop counter -> ack_valid
//
//   Ports
//     clk                 in   clock
//     rst                 in   synchronous reset, active-high
//     valid_ack_frag_in   in   ack_frag_recv valid this cycle
//     ack_frag_recv       in   AURORA_WIDTH received fragment
//     ack_valid           out  head-of-FIFO ACK available
//     ack_ready           in   consumer takes the head entry
//     ack_src_router      out  router that issued the ACK
//     ack_src_dfx         out  src DFX of the acked packet
//     ack_dst_dfx         out  dst DFX of the acked packet
//     ack_rn              out  request number carried by the ACK
//     ack_fifo_full       out  FIFO holds FIFO_DEPTH entries
//     drop_overflow_cnt   out  good frames lost to a full FIFO (saturating)
//     drop_malformed_cnt  out  frames that failed a header check (saturating)
//     clear_cnt           in   synchronous clear of both drop counters
//
//   Field widths must match the layout in ack_pkt_pkg; FIFO_DEPTH and
//   CNT_WIDTH are free.
// ---------------------------------------------------------------------------
module ack_pkt_parser
  import ack_pkt_pkg::*;
#(
  parameter int ACK_WIDTH     = ACK_W,
  parameter int SEQ_NUM_WIDTH = SEQ_W,
  parameter int DFX_WIDTH     = DFX_W,
  parameter int ROUTER_WIDTH  = ROUTER_W,
  parameter int AURORA_WIDTH  = AURORA_W,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_ack_frag_in,
  input  logic [AURORA_WIDTH-1:0]  ack_frag_recv,
  output logic                     ack_valid,
  input  logic                     ack_ready,
  output logic [ROUTER_WIDTH-1:0]  ack_src_router,
  output logic [DFX_WIDTH-1:0]     ack_src_dfx,
  output logic [DFX_WIDTH-1:0]     ack_dst_dfx,
  output logic [SEQ_NUM_WIDTH-1:0] ack_rn,
  output logic                     ack_fifo_full,
  output logic [CNT_WIDTH-1:0]     drop_overflow_cnt,
  output logic [CNT_WIDTH-1:0]     drop_malformed_cnt,
  input  logic                     clear_cnt
);

  localparam int PAD_W = AURORA_WIDTH - HDR_W;

  // ---------------- stage 1: fragment register ----------------
  logic                    s1_valid;
  logic [AURORA_WIDTH-1:0] s1_frag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= valid_ack_frag_in;
    end
  end

  // Data path only; s1_valid qualifies it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (valid_ack_frag_in) begin
      s1_frag <= ack_frag_recv;
    end
  end

  // ---------------- header check ----------------
  logic [ROUTER_WIDTH-1:0]  f_src_router;
  logic [DFX_WIDTH-1:0]     f_dst_dfx0;
  logic [RSV3_W-1:0]        f_rsv3;
  logic [TYPE_W-1:0]        f_type;
  logic [DFX_WIDTH-1:0]     f_src_dfx;
  logic [DFX_WIDTH-1:0]     f_dst_dfx1;
  logic [RSV1_W-1:0]        f_rsv1;
  logic [SEQ_NUM_WIDTH-1:0] f_rn;
  logic [ACK_WIDTH-1:0]     f_ack;
  logic [PAD_W-1:0]         f_pad;
  logic                     hdr_good;
  ack_entry_t               s1_entry;

  assign f_src_router = s1_frag[OFS_SRC_ROUTER +: ROUTER_WIDTH];
  assign f_dst_dfx0   = s1_frag[OFS_DST_DFX0   +: DFX_WIDTH];
  assign f_rsv3       = s1_frag[OFS_RSV3       +: RSV3_W];
  assign f_type       = s1_frag[OFS_TYPE       +: TYPE_W];
  assign f_src_dfx    = s1_frag[OFS_SRC_DFX    +: DFX_WIDTH];
  assign f_dst_dfx1   = s1_frag[OFS_DST_DFX1   +: DFX_WIDTH];
  assign f_rsv1       = s1_frag[OFS_RSV1       +: RSV1_W];
  assign f_rn         = s1_frag[OFS_RN         +: SEQ_NUM_WIDTH];
  assign f_ack        = s1_frag[OFS_ACK        +: ACK_WIDTH];
  assign f_pad        = s1_frag[AURORA_WIDTH-1:HDR_W];

  // The duplicated dst_dfx acts as a cheap integrity check on the header.
  assign hdr_good = (f_type == TYPE_ACK)
                  && (f_rsv3 == '0)
                  && (f_rsv1 == '0)
                  && (f_ack == ACK_WIDTH'(1))
                  && (f_dst_dfx0 == f_dst_dfx1)
                  && (f_pad == '0);

  assign s1_entry.src_router = f_src_router;
  assign s1_entry.src_dfx    = f_src_dfx;
  assign s1_entry.dst_dfx    = f_dst_dfx0;
  assign s1_entry.rn         = f_rn;

  // ---------------- stage 2: verdict register ----------------
  logic       s2_good;
  logic       s2_bad;
  ack_entry_t s2_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_good <= 1'b0;
      s2_bad  <= 1'b0;
    end else begin
      s2_good <= s1_valid & hdr_good;
      s2_bad  <= s1_valid & ~hdr_good;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      s2_entry <= s1_entry;
    end
  end

  // ---------------- decoded-ACK FIFO ----------------
  ack_entry_t head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       overflow_inc;

  assign pop = ack_valid & ack_ready;

  ack_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_good),
    .din   (s2_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A simultaneous pop frees the slot, so only push-without-pop on full drops.
  assign overflow_inc = s2_good & fifo_full & ~pop;

  assign ack_valid      = ~fifo_empty;
  assign ack_fifo_full  = fifo_full;
  assign ack_src_router = head.src_router;
  assign ack_src_dfx    = head.src_dfx;
  assign ack_dst_dfx    = head.dst_dfx;
  assign ack_rn         = head.rn;

  // ---------------- saturating drop counters ----------------
  // clear_cnt wins over an increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      drop_overflow_cnt <= '0;
    end else if (overflow_inc && (drop_overflow_cnt != '1)) begin
      drop_overflow_cnt <= drop_overflow_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      drop_malformed_cnt <= '0;
    end else if (s2_bad && (drop_malformed_cnt != '1)) begin
      drop_malformed_cnt <= drop_malformed_cnt + CNT_WIDTH'(1);
    end
  end

endmodule : ack_pkt_parser

// File: tb/tb_ack_pkt_parser.sv
// ---------------------------------------------------------------------------
// tb_ack_pkt_parser
//   Directed bench for ack_pkt_parser at default parameters. Inputs change and
//   outputs are sampled on the falling edge; the DUT acts on the rising edge.
//   Reference frame V = 16'hD709: src_router=1, dst_dfx=2, src_dfx=3, rn=1.
// ---------------------------------------------------------------------------
module tb_ack_pkt_parser;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_ack_frag_in;
  logic [255:0] ack_frag_recv;
  logic         ack_valid;
  logic         ack_ready;
  logic [1:0]   ack_src_router;
  logic [1:0]   ack_src_dfx;
  logic [1:0]   ack_dst_dfx;
  logic [0:0]   ack_rn;
  logic         ack_fifo_full;
  logic [7:0]   drop_overflow_cnt;
  logic [7:0]   drop_malformed_cnt;
  logic         clear_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ack_pkt_parser dut (
    .clk                (clk),
    .rst                (rst),
    .valid_ack_frag_in  (valid_ack_frag_in),
    .ack_frag_recv      (ack_frag_recv),
    .ack_valid          (ack_valid),
    .ack_ready          (ack_ready),
    .ack_src_router     (ack_src_router),
    .ack_src_dfx        (ack_src_dfx),
    .ack_dst_dfx        (ack_dst_dfx),
    .ack_rn             (ack_rn),
    .ack_fifo_full      (ack_fifo_full),
    .drop_overflow_cnt  (drop_overflow_cnt),
    .drop_malformed_cnt (drop_malformed_cnt),
    .clear_cnt          (clear_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [255:0] f16(input logic [15:0] h);
    return {240'h0, h};
  endfunction

  // Good frame with src_dfx=3, dst_dfx=2, rn=1 and the given router id.
  function automatic logic [255:0] fr(input int r);
    logic [15:0] h;
    h = 16'hD708 | 16'(r & 3);
    return {240'h0, h};
  endfunction

  localparam logic [15:0] V_HDR   = 16'hD709;
  localparam logic [15:0] V_RN0   = 16'h9709; // V with rn=0
  localparam logic [15:0] BAD_TYP = 16'hD689; // type bits [8:7] = 2'b01
  localparam logic [15:0] BAD_DST = 16'hCF09; // dst copies 2 and 1

  logic [255:0] v_pad;

  initial begin
    rst               = 1'b1;
    valid_ack_frag_in = 1'b0;
    ack_frag_recv     = '0;
    ack_ready         = 1'b0;
    clear_cnt         = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    // ---- reset state ----
    check("rst_valid",  {31'b0, ack_valid}, 0);
    check("rst_full",   {31'b0, ack_fifo_full}, 0);
    check("rst_fields", {25'b0, ack_src_router, ack_src_dfx, ack_dst_dfx, ack_rn}, 0);
    check("rst_ovf",    {24'b0, drop_overflow_cnt}, 0);
    check("rst_mal",    {24'b0, drop_malformed_cnt}, 0);

    // ---- 1: single good frame, two-cycle latency, one-cycle pulse ----
    ack_ready = 1'b1;
    valid_ack_frag_in = 1'b1;
    ack_frag_recv = f16(V_HDR);
    step();
    valid_ack_frag_in = 1'b0;
    check("t1_lat1", {31'b0, ack_valid}, 0);
    step();
    check("t1_lat2", {31'b0, ack_valid}, 0);
    step();
    check("t1_valid",  {31'b0, ack_valid}, 1);
    check("t1_router", {30'b0, ack_src_router}, 1);
    check("t1_srcdfx", {30'b0, ack_src_dfx}, 3);
    check("t1_dstdfx", {30'b0, ack_dst_dfx}, 2);
    check("t1_rn",     {31'b0, ack_rn}, 1);
    step();
    check("t1_pulse_end", {31'b0, ack_valid}, 0);
    check("t1_ovf", {24'b0, drop_overflow_cnt}, 0);
    check("t1_mal", {24'b0, drop_malformed_cnt}, 0);

    // ---- 2: malformed frames ----
    v_pad = f16(V_HDR);
    v_pad[200] = 1'b1;
    valid_ack_frag_in = 1'b1;
    ack_frag_recv = f16(BAD_TYP);
    step();
    ack_frag_recv = v_pad;
    step();
    ack_frag_recv = f16(BAD_DST);
    step();
    valid_ack_frag_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_no_valid", {31'b0, ack_valid}, 0);
      step();
    end
    check("t2_mal", {24'b0, drop_malformed_cnt}, 3);
    check("t2_ovf", {24'b0, drop_overflow_cnt}, 0);

    // ---- 3: overflow with ack_ready low, then drain ----
    ack_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_ack_frag_in = 1'b1;
      ack_frag_recv = (i % 2 == 0) ? f16(V_HDR) : f16(V_RN0);
      step();
    end
    valid_ack_frag_in = 1'b0;
    repeat (3) step();
    check("t3_full",  {31'b0, ack_fifo_full}, 1);
    check("t3_valid", {31'b0, ack_valid}, 1);
    check("t3_ovf",   {24'b0, drop_overflow_cnt}, 2);
    check("t3_hold_rn", {31'b0, ack_rn}, 1);
    ack_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_pop_valid", {31'b0, ack_valid}, 1);
      check("t3_pop_rn", {31'b0, ack_rn}, (i % 2 == 0) ? 1 : 0);
      step();
    end
    check("t3_empty_valid", {31'b0, ack_valid}, 0);
    check("t3_empty_full",  {31'b0, ack_fifo_full}, 0);

    // ---- 4: full FIFO with continuous push+pop, no drops ----
    ack_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      valid_ack_frag_in = 1'b1;
      ack_frag_recv = fr(r);
      step();
    end
    valid_ack_frag_in = 1'b0;
    repeat (3) step();
    check("t4_full", {31'b0, ack_fifo_full}, 1);
    // Two stream frames enter the pipeline before ack_ready rises, so the
    // first push reaches the FIFO in the same cycle as the first pop.
    for (int k = 0; k < 2; k++) begin
      valid_ack_frag_in = 1'b1;
      ack_frag_recv = fr(k);
      step();
    end
    for (int i = 0; i < 12; i++) begin
      ack_ready = 1'b1;
      check("t4_valid",  {31'b0, ack_valid}, 1);
      check("t4_router", {30'b0, ack_src_router}, i % 4);
      if (i < 8) check("t4_full_hold", {31'b0, ack_fifo_full}, 1);
      if (i + 2 < 8) begin
        valid_ack_frag_in = 1'b1;
        ack_frag_recv = fr(i + 2);
      end else begin
        valid_ack_frag_in = 1'b0;
      end
      step();
    end
    check("t4_drained", {31'b0, ack_valid}, 0);
    check("t4_ovf", {24'b0, drop_overflow_cnt}, 2);

    // ---- 5: reset one cycle after a frame ----
    valid_ack_frag_in = 1'b1;
    ack_frag_recv = f16(V_HDR);
    step();
    valid_ack_frag_in = 1'b0;
    rst = 1'b1;
    step();
    check("t5_valid",  {31'b0, ack_valid}, 0);
    check("t5_full",   {31'b0, ack_fifo_full}, 0);
    check("t5_fields", {25'b0, ack_src_router, ack_src_dfx, ack_dst_dfx, ack_rn}, 0);
    check("t5_ovf",    {24'b0, drop_overflow_cnt}, 0);
    check("t5_mal",    {24'b0, drop_malformed_cnt}, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_lost", {31'b0, ack_valid}, 0);
    end

    // ---- 6: saturation and clear priority ----
    valid_ack_frag_in = 1'b1;
    ack_frag_recv = f16(BAD_TYP);
    repeat (255) step();
    valid_ack_frag_in = 1'b0;
    repeat (3) step();
    check("t6_mal_ff", {24'b0, drop_malformed_cnt}, 32'hFF);
    valid_ack_frag_in = 1'b1;
    step();
    valid_ack_frag_in = 1'b0;
    repeat (3) step();
    check("t6_mal_sat", {24'b0, drop_malformed_cnt}, 32'hFF);
    check("t6_ovf", {24'b0, drop_overflow_cnt}, 0);

    // Frame driven at this edge increments at the edge two cycles later;
    // clear_cnt is raised for exactly that edge.
    valid_ack_frag_in = 1'b1;
    step();
    valid_ack_frag_in = 1'b0;
    step();
    clear_cnt = 1'b1;
    step();
    clear_cnt = 1'b0;
    check("t6_clr_at_ff", {24'b0, drop_malformed_cnt}, 0);

    valid_ack_frag_in = 1'b1;
    step();
    valid_ack_frag_in = 1'b0;
    repeat (3) step();
    check("t6_mal_one", {24'b0, drop_malformed_cnt}, 1);

    valid_ack_frag_in = 1'b1;
    step();
    valid_ack_frag_in = 1'b0;
    step();
    clear_cnt = 1'b1;
    step();
    clear_cnt = 1'b0;
    check("t6_clr_prio", {24'b0, drop_malformed_cnt}, 0);
    step();
    check("t6_clr_stay", {24'b0, drop_malformed_cnt}, 0);
    check("t6_no_valid", {31'b0, ack_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule : tb_ack_pkt_parser
